// File: rtl/dram_axi4_arbiter.sv
// rtl/dram_axi4_arbiter.sv - two-master AXI4 transaction arbiter in front of the DRAM controller M2 port
// Define DRAM_ARB_FIXED_PRIO_EN for fixed S0-over-S1 priority; round-robin otherwise.
module dram_axi4_arbiter #(
  parameter int AXI4_ID_WIDTH = 4,
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  // S0 (CPU)
  input  logic [AXI4_ID_WIDTH-2:0]   S0_AXI4_AWID,
  input  logic [ADDR_WIDTH-1:0]      S0_AXI4_AWADDR,
  input  logic [7:0]                 S0_AXI4_AWLEN,
  input  logic [2:0]                 S0_AXI4_AWSIZE,
  input  logic [1:0]                 S0_AXI4_AWBURST,
  input  logic                       S0_AXI4_AWVALID,
  output logic                       S0_AXI4_AWREADY,
  input  logic [DATA_WIDTH-1:0]      S0_AXI4_WDATA,
  input  logic [DATA_WIDTH/8-1:0]    S0_AXI4_WSTRB,
  input  logic                       S0_AXI4_WLAST,
  input  logic                       S0_AXI4_WVALID,
  output logic                       S0_AXI4_WREADY,
  output logic [AXI4_ID_WIDTH-2:0]   S0_AXI4_BID,
  output logic [1:0]                 S0_AXI4_BRESP,
  output logic                       S0_AXI4_BVALID,
  input  logic                       S0_AXI4_BREADY,
  input  logic [AXI4_ID_WIDTH-2:0]   S0_AXI4_ARID,
  input  logic [ADDR_WIDTH-1:0]      S0_AXI4_ARADDR,
  input  logic [7:0]                 S0_AXI4_ARLEN,
  input  logic [2:0]                 S0_AXI4_ARSIZE,
  input  logic [1:0]                 S0_AXI4_ARBURST,
  input  logic                       S0_AXI4_ARVALID,
  output logic                       S0_AXI4_ARREADY,
  output logic [AXI4_ID_WIDTH-2:0]   S0_AXI4_RID,
  output logic [DATA_WIDTH-1:0]      S0_AXI4_RDATA,
  output logic [1:0]                 S0_AXI4_RRESP,
  output logic                       S0_AXI4_RLAST,
  output logic                       S0_AXI4_RVALID,
  input  logic                       S0_AXI4_RREADY,
  // S1 (DMA)
  input  logic [AXI4_ID_WIDTH-2:0]   S1_AXI4_AWID,
  input  logic [ADDR_WIDTH-1:0]      S1_AXI4_AWADDR,
  input  logic [7:0]                 S1_AXI4_AWLEN,
  input  logic [2:0]                 S1_AXI4_AWSIZE,
  input  logic [1:0]                 S1_AXI4_AWBURST,
  input  logic                       S1_AXI4_AWVALID,
  output logic                       S1_AXI4_AWREADY,
  input  logic [DATA_WIDTH-1:0]      S1_AXI4_WDATA,
  input  logic [DATA_WIDTH/8-1:0]    S1_AXI4_WSTRB,
  input  logic                       S1_AXI4_WLAST,
  input  logic                       S1_AXI4_WVALID,
  output logic                       S1_AXI4_WREADY,
  output logic [AXI4_ID_WIDTH-2:0]   S1_AXI4_BID,
  output logic [1:0]                 S1_AXI4_BRESP,
  output logic                       S1_AXI4_BVALID,
  input  logic                       S1_AXI4_BREADY,
  input  logic [AXI4_ID_WIDTH-2:0]   S1_AXI4_ARID,
  input  logic [ADDR_WIDTH-1:0]      S1_AXI4_ARADDR,
  input  logic [7:0]                 S1_AXI4_ARLEN,
  input  logic [2:0]                 S1_AXI4_ARSIZE,
  input  logic [1:0]                 S1_AXI4_ARBURST,
  input  logic                       S1_AXI4_ARVALID,
  output logic                       S1_AXI4_ARREADY,
  output logic [AXI4_ID_WIDTH-2:0]   S1_AXI4_RID,
  output logic [DATA_WIDTH-1:0]      S1_AXI4_RDATA,
  output logic [1:0]                 S1_AXI4_RRESP,
  output logic                       S1_AXI4_RLAST,
  output logic                       S1_AXI4_RVALID,
  input  logic                       S1_AXI4_RREADY,
  // M2 (downstream controller port)
  output logic [AXI4_ID_WIDTH-1:0]   M2_AXI4_AWID,
  output logic [ADDR_WIDTH-1:0]      M2_AXI4_AWADDR,
  output logic [7:0]                 M2_AXI4_AWLEN,
  output logic [2:0]                 M2_AXI4_AWSIZE,
  output logic [1:0]                 M2_AXI4_AWBURST,
  output logic                       M2_AXI4_AWVALID,
  input  logic                       M2_AXI4_AWREADY,
  output logic [DATA_WIDTH-1:0]      M2_AXI4_WDATA,
  output logic [DATA_WIDTH/8-1:0]    M2_AXI4_WSTRB,
  output logic                       M2_AXI4_WLAST,
  output logic                       M2_AXI4_WVALID,
  input  logic                       M2_AXI4_WREADY,
  input  logic [AXI4_ID_WIDTH-1:0]   M2_AXI4_BID,
  input  logic [1:0]                 M2_AXI4_BRESP,
  input  logic                       M2_AXI4_BVALID,
  output logic                       M2_AXI4_BREADY,
  output logic [AXI4_ID_WIDTH-1:0]   M2_AXI4_ARID,
  output logic [ADDR_WIDTH-1:0]      M2_AXI4_ARADDR,
  output logic [7:0]                 M2_AXI4_ARLEN,
  output logic [2:0]                 M2_AXI4_ARSIZE,
  output logic [1:0]                 M2_AXI4_ARBURST,
  output logic                       M2_AXI4_ARVALID,
  input  logic                       M2_AXI4_ARREADY,
  input  logic [AXI4_ID_WIDTH-1:0]   M2_AXI4_RID,
  input  logic [DATA_WIDTH-1:0]      M2_AXI4_RDATA,
  input  logic [1:0]                 M2_AXI4_RRESP,
  input  logic                       M2_AXI4_RLAST,
  input  logic                       M2_AXI4_RVALID,
  output logic                       M2_AXI4_RREADY
);

  localparam int UIDW = AXI4_ID_WIDTH - 1;

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_e;

  state_e                  state_q, state_d;
  logic                    gnt_q, gnt_d;
  // One address-payload register set serves both AW and AR: only one is ever in flight.
  logic [UIDW-1:0]         id_q, id_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              len_q, len_d;
  logic [2:0]              size_q, size_d;
  logic [1:0]              burst_q, burst_d;

  logic                    req0, req1, pick, pick_aw, done;
  logic                    sel_wvalid, sel_wlast, sel_bready, sel_rready;
  logic                    st_waddr, st_wdata, st_wresp, st_raddr, st_rdata;

  // Per-master copies of the response payload so a non-granted master keeps its last values.
  logic [1:0][UIDW-1:0]       bid_q, rid_q;
  logic [1:0][1:0]            bresp_q, rresp_q;
  logic [1:0][DATA_WIDTH-1:0] rdata_q;
  logic [1:0]                 rlast_q;

  // Routing uses the latched grant only; the downstream ID MSB is deliberately ignored.
  logic unused_id_msb;
  assign unused_id_msb = M2_AXI4_BID[AXI4_ID_WIDTH-1] ^ M2_AXI4_RID[AXI4_ID_WIDTH-1];

  assign req0 = S0_AXI4_AWVALID | S0_AXI4_ARVALID;
  assign req1 = S1_AXI4_AWVALID | S1_AXI4_ARVALID;

  assign st_waddr = (state_q == WADDR);
  assign st_wdata = (state_q == WDATA);
  assign st_wresp = (state_q == WRESP);
  assign st_raddr = (state_q == RADDR);
  assign st_rdata = (state_q == RDATA);

  assign sel_wvalid = gnt_q ? S1_AXI4_WVALID : S0_AXI4_WVALID;
  assign sel_wlast  = gnt_q ? S1_AXI4_WLAST  : S0_AXI4_WLAST;
  assign sel_bready = gnt_q ? S1_AXI4_BREADY : S0_AXI4_BREADY;
  assign sel_rready = gnt_q ? S1_AXI4_RREADY : S0_AXI4_RREADY;

  // Transaction completes on the B handshake or the RLAST handshake.
  assign done = (st_wresp & M2_AXI4_BVALID & sel_bready) |
                (st_rdata & M2_AXI4_RVALID & sel_rready & M2_AXI4_RLAST);

`ifndef DRAM_ARB_FIXED_PRIO_EN
  logic last_q;

  // Last-grant pointer: reset to 1 so S0 wins the first contested arbitration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (done) begin
      last_q <= gnt_q;
    end
  end
`endif

  // FSM state, grant and latched address payload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
    end
  end

  // Arbitration in IDLE and phase sequencing of the granted transaction.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    pick    = 1'b0;
    pick_aw = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
          pick = ~req0;
`else
          pick = (req0 & req1) ? ~last_q : ~req0;
`endif
          pick_aw = pick ? S1_AXI4_AWVALID : S0_AXI4_AWVALID;
          gnt_d   = pick;
          if (pick_aw) begin
            state_d = WADDR;
            id_d    = pick ? S1_AXI4_AWID    : S0_AXI4_AWID;
            addr_d  = pick ? S1_AXI4_AWADDR  : S0_AXI4_AWADDR;
            len_d   = pick ? S1_AXI4_AWLEN   : S0_AXI4_AWLEN;
            size_d  = pick ? S1_AXI4_AWSIZE  : S0_AXI4_AWSIZE;
            burst_d = pick ? S1_AXI4_AWBURST : S0_AXI4_AWBURST;
          end else begin
            state_d = RADDR;
            id_d    = pick ? S1_AXI4_ARID    : S0_AXI4_ARID;
            addr_d  = pick ? S1_AXI4_ARADDR  : S0_AXI4_ARADDR;
            len_d   = pick ? S1_AXI4_ARLEN   : S0_AXI4_ARLEN;
            size_d  = pick ? S1_AXI4_ARSIZE  : S0_AXI4_ARSIZE;
            burst_d = pick ? S1_AXI4_ARBURST : S0_AXI4_ARBURST;
          end
        end
      end
      WADDR:   if (M2_AXI4_AWREADY) state_d = WDATA;
      WDATA:   if (sel_wvalid & M2_AXI4_WREADY & sel_wlast) state_d = WRESP;
      WRESP:   if (done) state_d = IDLE;
      RADDR:   if (M2_AXI4_ARREADY) state_d = RDATA;
      RDATA:   if (done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture whatever response payload the granted master is currently seeing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bid_q   <= '0;
      bresp_q <= '0;
      rid_q   <= '0;
      rresp_q <= '0;
      rdata_q <= '0;
      rlast_q <= '0;
    end else begin
      if (st_wresp) begin
        bid_q[gnt_q]   <= M2_AXI4_BID[UIDW-1:0];
        bresp_q[gnt_q] <= M2_AXI4_BRESP;
      end
      if (st_rdata) begin
        rid_q[gnt_q]   <= M2_AXI4_RID[UIDW-1:0];
        rresp_q[gnt_q] <= M2_AXI4_RRESP;
        rdata_q[gnt_q] <= M2_AXI4_RDATA;
        rlast_q[gnt_q] <= M2_AXI4_RLAST;
      end
    end
  end

  // Downstream address channels come from the latched payload, tagged with the master index.
  assign M2_AXI4_AWID    = {gnt_q, id_q};
  assign M2_AXI4_AWADDR  = addr_q;
  assign M2_AXI4_AWLEN   = len_q;
  assign M2_AXI4_AWSIZE  = size_q;
  assign M2_AXI4_AWBURST = burst_q;
  assign M2_AXI4_AWVALID = st_waddr;
  assign M2_AXI4_ARID    = {gnt_q, id_q};
  assign M2_AXI4_ARADDR  = addr_q;
  assign M2_AXI4_ARLEN   = len_q;
  assign M2_AXI4_ARSIZE  = size_q;
  assign M2_AXI4_ARBURST = burst_q;
  assign M2_AXI4_ARVALID = st_raddr;

  // W, B and R are zero-latency pass-throughs gated to the granted master.
  assign M2_AXI4_WDATA  = gnt_q ? S1_AXI4_WDATA : S0_AXI4_WDATA;
  assign M2_AXI4_WSTRB  = gnt_q ? S1_AXI4_WSTRB : S0_AXI4_WSTRB;
  assign M2_AXI4_WLAST  = sel_wlast;
  assign M2_AXI4_WVALID = st_wdata & sel_wvalid;
  assign M2_AXI4_BREADY = st_wresp & sel_bready;
  assign M2_AXI4_RREADY = st_rdata & sel_rready;

  assign S0_AXI4_AWREADY = st_waddr & ~gnt_q & M2_AXI4_AWREADY;
  assign S1_AXI4_AWREADY = st_waddr &  gnt_q & M2_AXI4_AWREADY;
  assign S0_AXI4_WREADY  = st_wdata & ~gnt_q & M2_AXI4_WREADY;
  assign S1_AXI4_WREADY  = st_wdata &  gnt_q & M2_AXI4_WREADY;
  assign S0_AXI4_BVALID  = st_wresp & ~gnt_q & M2_AXI4_BVALID;
  assign S1_AXI4_BVALID  = st_wresp &  gnt_q & M2_AXI4_BVALID;
  assign S0_AXI4_ARREADY = st_raddr & ~gnt_q & M2_AXI4_ARREADY;
  assign S1_AXI4_ARREADY = st_raddr &  gnt_q & M2_AXI4_ARREADY;
  assign S0_AXI4_RVALID  = st_rdata & ~gnt_q & M2_AXI4_RVALID;
  assign S1_AXI4_RVALID  = st_rdata &  gnt_q & M2_AXI4_RVALID;

  assign S0_AXI4_BID   = (st_wresp & ~gnt_q) ? M2_AXI4_BID[UIDW-1:0] : bid_q[0];
  assign S1_AXI4_BID   = (st_wresp &  gnt_q) ? M2_AXI4_BID[UIDW-1:0] : bid_q[1];
  assign S0_AXI4_BRESP = (st_wresp & ~gnt_q) ? M2_AXI4_BRESP : bresp_q[0];
  assign S1_AXI4_BRESP = (st_wresp &  gnt_q) ? M2_AXI4_BRESP : bresp_q[1];
  assign S0_AXI4_RID   = (st_rdata & ~gnt_q) ? M2_AXI4_RID[UIDW-1:0] : rid_q[0];
  assign S1_AXI4_RID   = (st_rdata &  gnt_q) ? M2_AXI4_RID[UIDW-1:0] : rid_q[1];
  assign S0_AXI4_RRESP = (st_rdata & ~gnt_q) ? M2_AXI4_RRESP : rresp_q[0];
  assign S1_AXI4_RRESP = (st_rdata &  gnt_q) ? M2_AXI4_RRESP : rresp_q[1];
  assign S0_AXI4_RDATA = (st_rdata & ~gnt_q) ? M2_AXI4_RDATA : rdata_q[0];
  assign S1_AXI4_RDATA = (st_rdata &  gnt_q) ? M2_AXI4_RDATA : rdata_q[1];
  assign S0_AXI4_RLAST = (st_rdata & ~gnt_q) ? M2_AXI4_RLAST : rlast_q[0];
  assign S1_AXI4_RLAST = (st_rdata &  gnt_q) ? M2_AXI4_RLAST : rlast_q[1];

endmodule

// File: tb/tb_dram_axi4_arbiter.sv
// tb/tb_dram_axi4_arbiter.sv - directed self-checking bench for dram_axi4_arbiter
module tb_dram_axi4_arbiter;

  logic clk = 1'b0;
  logic rst;

  logic [2:0]  S0_AXI4_AWID, S1_AXI4_AWID, S0_AXI4_ARID, S1_AXI4_ARID;
  logic [31:0] S0_AXI4_AWADDR, S1_AXI4_AWADDR, S0_AXI4_ARADDR, S1_AXI4_ARADDR;
  logic [7:0]  S0_AXI4_AWLEN, S1_AXI4_AWLEN, S0_AXI4_ARLEN, S1_AXI4_ARLEN;
  logic [2:0]  S0_AXI4_AWSIZE, S1_AXI4_AWSIZE, S0_AXI4_ARSIZE, S1_AXI4_ARSIZE;
  logic [1:0]  S0_AXI4_AWBURST, S1_AXI4_AWBURST, S0_AXI4_ARBURST, S1_AXI4_ARBURST;
  logic        S0_AXI4_AWVALID, S1_AXI4_AWVALID, S0_AXI4_ARVALID, S1_AXI4_ARVALID;
  logic        S0_AXI4_AWREADY, S1_AXI4_AWREADY, S0_AXI4_ARREADY, S1_AXI4_ARREADY;
  logic [31:0] S0_AXI4_WDATA, S1_AXI4_WDATA;
  logic [3:0]  S0_AXI4_WSTRB, S1_AXI4_WSTRB;
  logic        S0_AXI4_WLAST, S1_AXI4_WLAST, S0_AXI4_WVALID, S1_AXI4_WVALID;
  logic        S0_AXI4_WREADY, S1_AXI4_WREADY;
  logic [2:0]  S0_AXI4_BID, S1_AXI4_BID, S0_AXI4_RID, S1_AXI4_RID;
  logic [1:0]  S0_AXI4_BRESP, S1_AXI4_BRESP, S0_AXI4_RRESP, S1_AXI4_RRESP;
  logic        S0_AXI4_BVALID, S1_AXI4_BVALID, S0_AXI4_BREADY, S1_AXI4_BREADY;
  logic [31:0] S0_AXI4_RDATA, S1_AXI4_RDATA;
  logic        S0_AXI4_RLAST, S1_AXI4_RLAST, S0_AXI4_RVALID, S1_AXI4_RVALID;
  logic        S0_AXI4_RREADY, S1_AXI4_RREADY;

  logic [3:0]  M2_AXI4_AWID, M2_AXI4_ARID, M2_AXI4_BID, M2_AXI4_RID;
  logic [31:0] M2_AXI4_AWADDR, M2_AXI4_ARADDR, M2_AXI4_WDATA, M2_AXI4_RDATA;
  logic [7:0]  M2_AXI4_AWLEN, M2_AXI4_ARLEN;
  logic [2:0]  M2_AXI4_AWSIZE, M2_AXI4_ARSIZE;
  logic [1:0]  M2_AXI4_AWBURST, M2_AXI4_ARBURST, M2_AXI4_BRESP, M2_AXI4_RRESP;
  logic [3:0]  M2_AXI4_WSTRB;
  logic        M2_AXI4_AWVALID, M2_AXI4_AWREADY, M2_AXI4_WLAST, M2_AXI4_WVALID, M2_AXI4_WREADY;
  logic        M2_AXI4_BVALID, M2_AXI4_BREADY, M2_AXI4_ARVALID, M2_AXI4_ARREADY;
  logic        M2_AXI4_RLAST, M2_AXI4_RVALID, M2_AXI4_RREADY;

  dram_axi4_arbiter #(.AXI4_ID_WIDTH(4), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .S0_AXI4_AWID(S0_AXI4_AWID), .S0_AXI4_AWADDR(S0_AXI4_AWADDR), .S0_AXI4_AWLEN(S0_AXI4_AWLEN),
    .S0_AXI4_AWSIZE(S0_AXI4_AWSIZE), .S0_AXI4_AWBURST(S0_AXI4_AWBURST), .S0_AXI4_AWVALID(S0_AXI4_AWVALID),
    .S0_AXI4_AWREADY(S0_AXI4_AWREADY), .S0_AXI4_WDATA(S0_AXI4_WDATA), .S0_AXI4_WSTRB(S0_AXI4_WSTRB),
    .S0_AXI4_WLAST(S0_AXI4_WLAST), .S0_AXI4_WVALID(S0_AXI4_WVALID), .S0_AXI4_WREADY(S0_AXI4_WREADY),
    .S0_AXI4_BID(S0_AXI4_BID), .S0_AXI4_BRESP(S0_AXI4_BRESP), .S0_AXI4_BVALID(S0_AXI4_BVALID),
    .S0_AXI4_BREADY(S0_AXI4_BREADY), .S0_AXI4_ARID(S0_AXI4_ARID), .S0_AXI4_ARADDR(S0_AXI4_ARADDR),
    .S0_AXI4_ARLEN(S0_AXI4_ARLEN), .S0_AXI4_ARSIZE(S0_AXI4_ARSIZE), .S0_AXI4_ARBURST(S0_AXI4_ARBURST),
    .S0_AXI4_ARVALID(S0_AXI4_ARVALID), .S0_AXI4_ARREADY(S0_AXI4_ARREADY), .S0_AXI4_RID(S0_AXI4_RID),
    .S0_AXI4_RDATA(S0_AXI4_RDATA), .S0_AXI4_RRESP(S0_AXI4_RRESP), .S0_AXI4_RLAST(S0_AXI4_RLAST),
    .S0_AXI4_RVALID(S0_AXI4_RVALID), .S0_AXI4_RREADY(S0_AXI4_RREADY),
    .S1_AXI4_AWID(S1_AXI4_AWID), .S1_AXI4_AWADDR(S1_AXI4_AWADDR), .S1_AXI4_AWLEN(S1_AXI4_AWLEN),
    .S1_AXI4_AWSIZE(S1_AXI4_AWSIZE), .S1_AXI4_AWBURST(S1_AXI4_AWBURST), .S1_AXI4_AWVALID(S1_AXI4_AWVALID),
    .S1_AXI4_AWREADY(S1_AXI4_AWREADY), .S1_AXI4_WDATA(S1_AXI4_WDATA), .S1_AXI4_WSTRB(S1_AXI4_WSTRB),
    .S1_AXI4_WLAST(S1_AXI4_WLAST), .S1_AXI4_WVALID(S1_AXI4_WVALID), .S1_AXI4_WREADY(S1_AXI4_WREADY),
    .S1_AXI4_BID(S1_AXI4_BID), .S1_AXI4_BRESP(S1_AXI4_BRESP), .S1_AXI4_BVALID(S1_AXI4_BVALID),
    .S1_AXI4_BREADY(S1_AXI4_BREADY), .S1_AXI4_ARID(S1_AXI4_ARID), .S1_AXI4_ARADDR(S1_AXI4_ARADDR),
    .S1_AXI4_ARLEN(S1_AXI4_ARLEN), .S1_AXI4_ARSIZE(S1_AXI4_ARSIZE), .S1_AXI4_ARBURST(S1_AXI4_ARBURST),
    .S1_AXI4_ARVALID(S1_AXI4_ARVALID), .S1_AXI4_ARREADY(S1_AXI4_ARREADY), .S1_AXI4_RID(S1_AXI4_RID),
    .S1_AXI4_RDATA(S1_AXI4_RDATA), .S1_AXI4_RRESP(S1_AXI4_RRESP), .S1_AXI4_RLAST(S1_AXI4_RLAST),
    .S1_AXI4_RVALID(S1_AXI4_RVALID), .S1_AXI4_RREADY(S1_AXI4_RREADY),
    .M2_AXI4_AWID(M2_AXI4_AWID), .M2_AXI4_AWADDR(M2_AXI4_AWADDR), .M2_AXI4_AWLEN(M2_AXI4_AWLEN),
    .M2_AXI4_AWSIZE(M2_AXI4_AWSIZE), .M2_AXI4_AWBURST(M2_AXI4_AWBURST), .M2_AXI4_AWVALID(M2_AXI4_AWVALID),
    .M2_AXI4_AWREADY(M2_AXI4_AWREADY), .M2_AXI4_WDATA(M2_AXI4_WDATA), .M2_AXI4_WSTRB(M2_AXI4_WSTRB),
    .M2_AXI4_WLAST(M2_AXI4_WLAST), .M2_AXI4_WVALID(M2_AXI4_WVALID), .M2_AXI4_WREADY(M2_AXI4_WREADY),
    .M2_AXI4_BID(M2_AXI4_BID), .M2_AXI4_BRESP(M2_AXI4_BRESP), .M2_AXI4_BVALID(M2_AXI4_BVALID),
    .M2_AXI4_BREADY(M2_AXI4_BREADY), .M2_AXI4_ARID(M2_AXI4_ARID), .M2_AXI4_ARADDR(M2_AXI4_ARADDR),
    .M2_AXI4_ARLEN(M2_AXI4_ARLEN), .M2_AXI4_ARSIZE(M2_AXI4_ARSIZE), .M2_AXI4_ARBURST(M2_AXI4_ARBURST),
    .M2_AXI4_ARVALID(M2_AXI4_ARVALID), .M2_AXI4_ARREADY(M2_AXI4_ARREADY), .M2_AXI4_RID(M2_AXI4_RID),
    .M2_AXI4_RDATA(M2_AXI4_RDATA), .M2_AXI4_RRESP(M2_AXI4_RRESP), .M2_AXI4_RLAST(M2_AXI4_RLAST),
    .M2_AXI4_RVALID(M2_AXI4_RVALID), .M2_AXI4_RREADY(M2_AXI4_RREADY)
  );

  always #5 clk = ~clk;

  wire [1:0] awready = {S1_AXI4_AWREADY, S0_AXI4_AWREADY};
  wire [1:0] wready  = {S1_AXI4_WREADY,  S0_AXI4_WREADY};
  wire [1:0] bvalid  = {S1_AXI4_BVALID,  S0_AXI4_BVALID};
  wire [1:0] arready = {S1_AXI4_ARREADY, S0_AXI4_ARREADY};
  wire [1:0] rvalid  = {S1_AXI4_RVALID,  S0_AXI4_RVALID};
  wire [14:0] rv_all = {awready, wready, bvalid, arready, rvalid, M2_AXI4_AWVALID,
                        M2_AXI4_WVALID, M2_AXI4_ARVALID, M2_AXI4_BREADY, M2_AXI4_RREADY};

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    bit          m;
    bit          wr;
    logic [2:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  resp;
    logic [3:0]  exp_m2_id;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] wpat(input logic [31:0] a, input int b);
    return (a << 4) + 32'hC0DE0000 + 32'(b);
  endfunction

  function automatic logic [31:0] rpat(input logic [31:0] a, input int b);
    return {a[15:0], 16'hBE00} + 32'(b * 3);
  endfunction

  task automatic set_aw(input bit m, input logic v, input logic [2:0] id, input logic [31:0] a, input logic [7:0] len);
    if (!m) begin
      S0_AXI4_AWVALID = v; S0_AXI4_AWID = id; S0_AXI4_AWADDR = a; S0_AXI4_AWLEN = len;
      S0_AXI4_AWSIZE = 3'd2; S0_AXI4_AWBURST = 2'b01;
    end else begin
      S1_AXI4_AWVALID = v; S1_AXI4_AWID = id; S1_AXI4_AWADDR = a; S1_AXI4_AWLEN = len;
      S1_AXI4_AWSIZE = 3'd2; S1_AXI4_AWBURST = 2'b01;
    end
  endtask

  task automatic set_ar(input bit m, input logic v, input logic [2:0] id, input logic [31:0] a, input logic [7:0] len);
    if (!m) begin
      S0_AXI4_ARVALID = v; S0_AXI4_ARID = id; S0_AXI4_ARADDR = a; S0_AXI4_ARLEN = len;
      S0_AXI4_ARSIZE = 3'd2; S0_AXI4_ARBURST = 2'b01;
    end else begin
      S1_AXI4_ARVALID = v; S1_AXI4_ARID = id; S1_AXI4_ARADDR = a; S1_AXI4_ARLEN = len;
      S1_AXI4_ARSIZE = 3'd2; S1_AXI4_ARBURST = 2'b01;
    end
  endtask

  task automatic set_w(input bit m, input logic v, input logic [31:0] d, input logic last);
    if (!m) begin
      S0_AXI4_WVALID = v; S0_AXI4_WDATA = d; S0_AXI4_WLAST = last; S0_AXI4_WSTRB = 4'hF;
    end else begin
      S1_AXI4_WVALID = v; S1_AXI4_WDATA = d; S1_AXI4_WLAST = last; S1_AXI4_WSTRB = 4'hF;
    end
  endtask

  task automatic set_bready(input bit m, input logic v);
    if (!m) S0_AXI4_BREADY = v; else S1_AXI4_BREADY = v;
  endtask

  task automatic set_rready(input bit m, input logic v);
    if (!m) S0_AXI4_RREADY = v; else S1_AXI4_RREADY = v;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at a negedge with the master's AW request already presented and the arbiter idle.
  task automatic serve_write(input bit m, input logic [2:0] id, input logic [31:0] a, input logic [7:0] len,
                             input logic [3:0] exp_id, input logic [1:0] resp);
    bit o;
    o = ~m;
    set_w(m, 1'b1, wpat(a, 0), len == 8'd0);
    #1 chk("wready before grant", wready[m], 1'b0);
    cycle();
    chk("m2 awvalid", M2_AXI4_AWVALID, 1'b1);
    chk("m2 awid", M2_AXI4_AWID, exp_id);
    chk("m2 awaddr", M2_AXI4_AWADDR, a);
    chk("m2 awlen", M2_AXI4_AWLEN, len);
    chk("m2 awsize/burst", {M2_AXI4_AWSIZE, M2_AXI4_AWBURST}, 5'b010_01);
    chk("m2 wvalid held off", M2_AXI4_WVALID, 1'b0);
    chk("m2 arvalid during write", M2_AXI4_ARVALID, 1'b0);
    M2_AXI4_AWREADY = 1'b1;
    #1 chk("awready granted", awready[m], 1'b1);
    chk("other quiet aw", {awready[o], wready[o], bvalid[o], arready[o], rvalid[o]}, 5'd0);
    cycle();
    set_aw(m, 1'b0, 3'd0, 32'd0, 8'd0);
    M2_AXI4_AWREADY = 1'b0;
    M2_AXI4_WREADY = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      set_w(m, 1'b1, wpat(a, b), b == int'(len));
      #1 chk("m2 wvalid", M2_AXI4_WVALID, 1'b1);
      chk("m2 wdata", M2_AXI4_WDATA, wpat(a, b));
      chk("m2 wlast", M2_AXI4_WLAST, b == int'(len));
      chk("wready granted", wready[m], 1'b1);
      cycle();
    end
    set_w(m, 1'b0, 32'd0, 1'b0);
    M2_AXI4_WREADY = 1'b0;
    M2_AXI4_BVALID = 1'b1;
    M2_AXI4_BID = exp_id;
    M2_AXI4_BRESP = resp;
    set_bready(m, 1'b1);
    #1 chk("bvalid granted", bvalid[m], 1'b1);
    chk("bid", m ? S1_AXI4_BID : S0_AXI4_BID, id);
    chk("bresp", m ? S1_AXI4_BRESP : S0_AXI4_BRESP, resp);
    chk("m2 bready", M2_AXI4_BREADY, 1'b1);
    chk("other quiet b", {awready[o], wready[o], bvalid[o], arready[o], rvalid[o]}, 5'd0);
    cycle();
    M2_AXI4_BVALID = 1'b0;
    set_bready(m, 1'b0);
  endtask

  // Entered at a negedge with the master's AR request already presented and the arbiter idle.
  task automatic serve_read(input bit m, input logic [2:0] id, input logic [31:0] a, input logic [7:0] len,
                            input logic [3:0] exp_id, input logic [1:0] resp, input int stall_beat);
    bit o;
    o = ~m;
    cycle();
    chk("m2 arvalid", M2_AXI4_ARVALID, 1'b1);
    chk("m2 arid", M2_AXI4_ARID, exp_id);
    chk("m2 araddr", M2_AXI4_ARADDR, a);
    chk("m2 arlen", M2_AXI4_ARLEN, len);
    chk("m2 awvalid during read", M2_AXI4_AWVALID, 1'b0);
    M2_AXI4_ARREADY = 1'b1;
    #1 chk("arready granted", arready[m], 1'b1);
    chk("other quiet ar", {awready[o], wready[o], bvalid[o], arready[o], rvalid[o]}, 5'd0);
    cycle();
    set_ar(m, 1'b0, 3'd0, 32'd0, 8'd0);
    M2_AXI4_ARREADY = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      M2_AXI4_RVALID = 1'b1;
      M2_AXI4_RDATA = rpat(a, b);
      M2_AXI4_RID = exp_id;
      M2_AXI4_RLAST = (b == int'(len));
      M2_AXI4_RRESP = resp;
      if (b == stall_beat) begin
        for (int s = 0; s < 3; s++) begin
          set_rready(m, 1'b0);
          #1 chk("m2 rready stalled", M2_AXI4_RREADY, 1'b0);
          chk("rvalid while stalled", rvalid[m], 1'b1);
          cycle();
        end
      end
      set_rready(m, 1'b1);
      #1 chk("rvalid granted", rvalid[m], 1'b1);
      chk("rdata", m ? S1_AXI4_RDATA : S0_AXI4_RDATA, rpat(a, b));
      chk("rid", m ? S1_AXI4_RID : S0_AXI4_RID, id);
      chk("rlast", m ? S1_AXI4_RLAST : S0_AXI4_RLAST, b == int'(len));
      chk("rresp", m ? S1_AXI4_RRESP : S0_AXI4_RRESP, resp);
      chk("m2 rready", M2_AXI4_RREADY, 1'b1);
      chk("other quiet r", rvalid[o], 1'b0);
      cycle();
    end
    M2_AXI4_RVALID = 1'b0;
    M2_AXI4_RLAST = 1'b0;
    set_rready(m, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 3'd5, 32'h100, 8'd3, 2'd0, 4'h5};
    vecs[1] = '{1'b1, 1'b1, 3'd2, 32'h140, 8'd0, 2'd2, 4'hA};
    vecs[2] = '{1'b0, 1'b0, 3'd7, 32'h180, 8'd1, 2'd0, 4'h7};
    vecs[3] = '{1'b1, 1'b0, 3'd3, 32'h1C0, 8'd2, 2'd1, 4'hB};
    vecs[4] = '{1'b1, 1'b1, 3'd0, 32'h1E0, 8'd1, 2'd0, 4'h8};
    vecs[5] = '{1'b0, 1'b0, 3'd1, 32'h1F0, 8'd0, 2'd3, 4'h1};

    rst = 1'b1;
    set_aw(1'b0, 1'b0, 3'd0, 32'd0, 8'd0); set_aw(1'b1, 1'b0, 3'd0, 32'd0, 8'd0);
    set_ar(1'b0, 1'b0, 3'd0, 32'd0, 8'd0); set_ar(1'b1, 1'b0, 3'd0, 32'd0, 8'd0);
    set_w(1'b0, 1'b0, 32'd0, 1'b0); set_w(1'b1, 1'b0, 32'd0, 1'b0);
    set_bready(1'b0, 1'b0); set_bready(1'b1, 1'b0);
    set_rready(1'b0, 1'b0); set_rready(1'b1, 1'b0);
    M2_AXI4_AWREADY = 1'b0; M2_AXI4_WREADY = 1'b0; M2_AXI4_ARREADY = 1'b0;
    M2_AXI4_BID = 4'd0; M2_AXI4_BRESP = 2'd0; M2_AXI4_BVALID = 1'b0;
    M2_AXI4_RID = 4'd0; M2_AXI4_RDATA = 32'd0; M2_AXI4_RRESP = 2'd0;
    M2_AXI4_RLAST = 1'b0; M2_AXI4_RVALID = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk("ready/valid in reset", rv_all, 15'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("ready/valid after reset", rv_all, 15'd0);
    @(negedge clk);

    // Contested reads straight out of reset: S0 first, then S1 after one idle cycle.
    set_ar(1'b0, 1'b1, 3'd4, 32'h200, 8'd1);
    set_ar(1'b1, 1'b1, 3'd6, 32'h300, 8'd1);
    serve_read(1'b0, 3'd4, 32'h200, 8'd1, 4'h4, 2'd0, -1);
    #1 chk("idle turnaround arvalid", M2_AXI4_ARVALID, 1'b0);
    serve_read(1'b1, 3'd6, 32'h300, 8'd1, 4'hE, 2'd0, -1);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].wr) begin
        set_aw(vecs[i].m, 1'b1, vecs[i].id, vecs[i].addr, vecs[i].len);
        serve_write(vecs[i].m, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].exp_m2_id, vecs[i].resp);
      end else begin
        set_ar(vecs[i].m, 1'b1, vecs[i].id, vecs[i].addr, vecs[i].len);
        serve_read(vecs[i].m, vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].exp_m2_id, vecs[i].resp, -1);
      end
    end

    // S0 was served last, so a contested pair of writes goes to S1 first under round-robin.
    set_aw(1'b0, 1'b1, 3'd1, 32'h500, 8'd0);
    set_aw(1'b1, 1'b1, 3'd2, 32'h600, 8'd0);
`ifdef DRAM_ARB_FIXED_PRIO_EN
    serve_write(1'b0, 3'd1, 32'h500, 8'd0, 4'h1, 2'd0);
    serve_write(1'b1, 3'd2, 32'h600, 8'd0, 4'hA, 2'd0);
`else
    serve_write(1'b1, 3'd2, 32'h600, 8'd0, 4'hA, 2'd0);
    serve_write(1'b0, 3'd1, 32'h500, 8'd0, 4'h1, 2'd0);
`endif

    // S1 presents AW and AR together: the write completes through B before AR goes out.
    set_aw(1'b1, 1'b1, 3'd3, 32'h700, 8'd2);
    set_ar(1'b1, 1'b1, 3'd5, 32'h780, 8'd1);
    serve_write(1'b1, 3'd3, 32'h700, 8'd2, 4'hB, 2'd0);
    #1 chk("ar waits for idle", M2_AXI4_ARVALID, 1'b0);
    serve_read(1'b1, 3'd5, 32'h780, 8'd1, 4'hD, 2'd0, -1);

    // S0 read with the second beat back-pressured for three cycles.
    set_ar(1'b0, 1'b1, 3'd2, 32'h800, 8'd3);
    serve_read(1'b0, 3'd2, 32'h800, 8'd3, 4'h2, 2'd0, 1);

    // Reset in the middle of an S0 write burst.
    set_aw(1'b0, 1'b1, 3'd1, 32'h900, 8'd3);
    cycle();
    M2_AXI4_AWREADY = 1'b1;
    cycle();
    set_aw(1'b0, 1'b0, 3'd0, 32'd0, 8'd0);
    M2_AXI4_AWREADY = 1'b0;
    M2_AXI4_WREADY = 1'b1;
    set_w(1'b0, 1'b1, wpat(32'h900, 0), 1'b0);
    #1 chk("wready before mid-burst reset", S0_AXI4_WREADY, 1'b1);
    rst = 1'b1;
    #1 chk("ready/valid on async reset", rv_all, 15'd0);
    cycle();
    set_w(1'b0, 1'b0, 32'd0, 1'b0);
    M2_AXI4_WREADY = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    set_aw(1'b0, 1'b1, 3'd6, 32'hA00, 8'd0);
    set_aw(1'b1, 1'b1, 3'd7, 32'hB00, 8'd0);
    serve_write(1'b0, 3'd6, 32'hA00, 8'd0, 4'h6, 2'd0);
    serve_write(1'b1, 3'd7, 32'hB00, 8'd0, 4'hF, 2'd1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dram_axi4_arbiter.md
# dram_axi4_arbiter

Two-master AXI4 arbiter that sits directly upstream of the DRAM controller's M2 AXI4 slave port. It serialises complete read and write transactions from master S0 (CPU) and master S1 (DMA) onto a single downstream port, one transaction outstanding at a time, which matches the controller's single-threaded read/write state machine. It tags the downstream ID with the master index and routes responses back to the master that was granted.

## Interface
- AXI4_ID_WIDTH, default 4: downstream ID width; each upstream ID is AXI4_ID_WIDTH-1 bits.
- ADDR_WIDTH, default 32: address width.
- DATA_WIDTH, default 32: data width; strobe width is DATA_WIDTH/8.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- Sx_AXI4_AWID/AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  in  ID-1/ADDR/8/3/2/1  upstream write address, x = 0,1.
- Sx_AXI4_AWREADY  out  1  write address accept.
- Sx_AXI4_WDATA/WSTRB/WLAST/WVALID  in  DATA/DATA/8/1/1  upstream write data.
- Sx_AXI4_WREADY  out  1  write data accept.
- Sx_AXI4_BID/BRESP/BVALID  out  ID-1/2/1  write response; Sx_AXI4_BREADY in 1.
- Sx_AXI4_ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  in  ID-1/ADDR/8/3/2/1  upstream read address; Sx_AXI4_ARREADY out 1.
- Sx_AXI4_RID/RDATA/RRESP/RLAST/RVALID  out  ID-1/DATA/2/1/1  read data; Sx_AXI4_RREADY in 1.
- M2_AXI4_* (AW, W, B, AR, R channels)  opposite directions  full widths  downstream port, same signal set as above with AXI4_ID_WIDTH IDs.

## Operation
- States: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA.
- IDLE: evaluate four requests (S0 AW, S0 AR, S1 AW, S1 AR). Master choice is round-robin: the master not granted last wins when both request. Within the chosen master, AW beats AR. Grant, direction and master index are registered; next state WADDR or RADDR.
- WADDR: drive M2 AW from the granted master. Set downstream AWID = {master index, upstream AWID}. Pass AWREADY to the granted master only. On the AW handshake, go to WDATA.
- WDATA: W channel is a combinational pass-through between the granted master and M2. Non-granted WREADY = 0. On a handshake with WLAST = 1, go to WRESP.
- WRESP: route M2 B to the granted master with BID = M2 BID[ID-2:0]. On the B handshake, update the last-grant pointer and go to IDLE.
- RADDR/RDATA: mirror of the write path. ARID is tagged the same way. R beats pass through. A handshake with RLAST = 1 updates the pointer and returns to IDLE.
- The routing decision uses the latched grant only; the ID MSB is not used for routing.
- The non-granted master sees all READY and VALID outputs at 0. Its own outputs hold their last values.

## Timing
- Reset: every Sx READY/VALID output, M2 AWVALID/WVALID/ARVALID, and M2 BREADY/RREADY are 0. State is IDLE. The last-grant pointer is 1, so S0 wins first.
- Arbitration latency: a request sampled in IDLE produces M2 AWVALID/ARVALID on the next cycle.
- Once M2 VALID is asserted, it and the payload are held stable until READY.
- Data and response beats add zero cycles; combinational valid/ready paths are limited to the granted master.
- Minimum transaction turnaround: 1 IDLE cycle between the final B/R handshake and the next address.
- AWLEN = 0 / ARLEN = 0: a single-beat burst; the WLAST or RLAST beat ends the phase immediately.
- Upstream WVALID before AW is granted: held off with WREADY = 0.
- Reset asserted mid-transaction: all outputs return to reset values immediately (asynchronous). Any partial burst is abandoned; the downstream controller is reset by the same source.

## Configuration
- DRAM_ARB_FIXED_PRIO_EN defined: S0 always wins over S1 when both request in IDLE. The last-grant pointer is not implemented.
- Not defined: round-robin as described above.

## Test plan
- S0 writes AWADDR=0x100, AWLEN=3, AWID=5 → M2 AWID=0x5, 4 W beats pass through, S0 BID=5 BRESP=0; S1 sees no READY/VALID.
- S0 and S1 both assert ARVALID in the same cycle after reset (ARADDR 0x200 and 0x300) → S0 is served first, then S1. M2 ARID MSB is 0 then 1; S1 RID low bits match its request.
- S1 asserts AWVALID and ARVALID together → write is completed through B before AR is forwarded.
- M2 RREADY back-pressure: stall S0 RREADY for 3 cycles mid-burst → M2 RREADY = 0 for those cycles and RDATA is delivered in order.
- Assert rst during the WDATA phase → all VALID/READY outputs are 0 the same cycle; the first post-reset request is granted to S0.
- With DRAM_ARB_FIXED_PRIO_EN, S0 and S1 continuously request single reads → only S0 is ever granted.
